// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sersub_pkg
// Purpose  : Shared definitions for the bit-serial subtractor: FSM state
//            encoding and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERSUB_DEFAULT_WIDTH = 8;

endpackage : sersub_pkg
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : half_subtractor
// Purpose  : One-bit half subtractor, x - y.
// Ports    : x  - minuend bit
//            y  - subtrahend bit
//            d  - difference bit (x ^ y)
//            bo - borrow out (~x & y)
// Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule : half_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor computing a - b, one bit per clock, LSB
//            first, with a registered borrow. A start/done handshake brackets
//            each operation; results hold until the next accepted start.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request a new operation (sampled in IDLE/DONE only)
//            a, b   - minuend / subtrahend, captured on accepted start
//            busy   - high during the WIDTH bit cycles
//            done   - one-cycle pulse when diff/borrow are valid
//            diff   - a - b modulo 2^WIDTH
//            ovf    - signed overflow (only with SERSUB_OVERFLOW_EN)
//            borrow - final borrow, 1 iff a < b unsigned
// Config   : `define SERSUB_OVERFLOW_EN adds the ovf port and its flop.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             bin;

    logic             d1;
    logic             bo1;
    logic             bo2;
    logic             d_bit;
    logic             bout;

    // Full-subtract cell: (a_i - b_i) then (result - borrow_in).
    half_subtractor u_hs_ab (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .d  (d1),
        .bo (bo1)
    );

    half_subtractor u_hs_bin (
        .x  (d1),
        .y  (bin),
        .d  (d_bit),
        .bo (bo2)
    );

    assign bout = bo1 | bo2;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_bit = (state == RUN) && (cnt == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign borrow   = bin;

    // ------------------------------------------------------------------------
    // Datapath: operands shift right, difference bits enter diff at the MSB
    // so that after WIDTH shifts bit 0 has reached diff[0].
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            bin  <= 1'b0;
            diff <= '0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            bin  <= 1'b0;
            diff <= '0;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            bin  <= bout;
            diff <= {d_bit, diff[WIDTH-1:1]};
        end
    end

`ifdef SERSUB_OVERFLOW_EN
    // On the last bit cycle the operand LSBs are the original MSBs and d_bit
    // is the result MSB, so no separate MSB capture is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
        end
    end
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERSUB_OVERFLOW_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERSUB_OVERFLOW_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        if (r < 0) r = r + (1 << W);
        return W'(r);
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (int'(x) < int'(y));
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r < -(1 << (W-1))) || (r > ((1 << (W-1)) - 1));
    endfunction

    // One operation from IDLE. If glitch > 0, start is re-pulsed with
    // a=b=0xFF in that RUN cycle; it must not disturb the result.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input int glitch, input string name);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == glitch) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
        end while (!done && cycles < 40);
        check({name, "_latency"}, cycles, W + 1);
        check({name, "_busy_cycles"}, busy_cnt, W);
        check({name, "_diff"}, diff, ed);
        check({name, "_borrow"}, borrow, eb);
`ifdef SERSUB_OVERFLOW_EN
        check({name, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("note: unexpected X in expected ovf");
`endif
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_diff_hold"}, diff, ed);
    endtask

    initial begin
        int cycles;
        int done_seen;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] exp_d;
        logic         exp_b;

        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h10, 8'h10, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow, 0);
`ifdef SERSUB_OVERFLOW_EN
        check("reset_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov, 0,
                   $sformatf("vec%0d", i));
        end

        // start during RUN is ignored
        run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 3, "start_in_run");

        // Reset in the 4th RUN cycle: outputs clear immediately, no done
        @(negedge clk);
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op(8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 0, "after_abort");

        // Randomized against the model
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            run_op(x, y, m_diff(x, y), m_borrow(x, y), m_ovf(x, y), 0,
                   $sformatf("rand%0d", i));
        end

        // Back-to-back with start held high
        @(negedge clk);
        x = W'($urandom);
        y = W'($urandom);
        start = 1'b1;
        a     = x;
        b     = y;
        for (int k = 0; k < 6; k++) begin
            exp_d  = m_diff(x, y);
            exp_b  = m_borrow(x, y);
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (!done && cycles < 40);
            check($sformatf("b2b%0d_period", k), cycles, W + 1);
            check($sformatf("b2b%0d_diff", k), diff, exp_d);
            check($sformatf("b2b%0d_borrow", k), borrow, exp_b);
`ifdef SERSUB_OVERFLOW_EN
            check($sformatf("b2b%0d_ovf", k), ovf, m_ovf(x, y));
`endif
            // New operands captured at the edge that ends this DONE cycle.
            x = W'($urandom);
            y = W'($urandom);
            a = x;
            b = y;
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("final_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
